// File: rtl/serializador_ordenado.sv
// -----------------------------------------------------------------------------
// serializador_ordenado
//
// Output-side serializer for the nibble sorter. A `load` seen in IDLE captures
// the parallel `ordenado` array into an internal buffer. The buffer is then
// streamed one element per valid/ready transfer. `out_last` marks the final
// element, and a one-cycle `done` pulse follows the last transfer.
//
// Parameters:
//   WIDTH     bits per element
//   N         elements per frame
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   load       in   capture `ordenado` and start a frame (sampled in IDLE only)
//   ordenado   in   parallel sorted array, element i = ordenado[i]
//   out_ready  in   downstream accepts the current element
//   out_valid  out  out_data holds a valid element
//   out_data   out  current element, 0 when out_valid = 0
//   out_last   out  current element is the last of the frame
//   busy       out  high in any state other than IDLE
//   done       out  one-cycle pulse after the last transfer
//
// Build option:
//   SERIALIZADOR_REVERSE_EN  defined -> elements are emitted from index N-1
//                            down to 0; undefined -> from index 0 up to N-1.
// -----------------------------------------------------------------------------
module serializador_ordenado #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N     = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [N-1:0][WIDTH-1:0] ordenado,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

`ifdef SERIALIZADOR_REVERSE_EN
    localparam logic [IDX_W-1:0] START_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] END_IDX   = '0;
`else
    localparam logic [IDX_W-1:0] START_IDX = '0;
    localparam logic [IDX_W-1:0] END_IDX   = IDX_W'(N - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N-1:0][WIDTH-1:0] buf_q;
    logic                    capture;
    logic                    is_last;

    assign is_last = (idx_q == END_IDX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        capture   = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (load) begin
                    capture = 1'b1;
                    idx_d   = START_IDX;
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = buf_q[idx_q];
                out_last  = is_last;
                // The end index is never stepped past, so idx stays in range.
                if (out_ready) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
`ifdef SERIALIZADOR_REVERSE_EN
                        idx_d = idx_q - IDX_W'(1);
`else
                        idx_d = idx_q + IDX_W'(1);
`endif
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                buf_q <= ordenado;
            end
        end
    end

endmodule

// File: doc/serializador_ordenado.md
# serializador_ordenado

Output-side serializer for the 9-element nibble sorter. On a `load` pulse it captures the parallel sorted array (`ordenado`) into an internal buffer, then streams the elements one per transfer on a valid/ready interface, flagging the final element with `out_last`. It signals frame completion with a one-cycle `done` pulse. The serializer sits between the sorter output and any narrow downstream consumer (display driver, UART, memory writer).

## Interface
- `WIDTH`, default 4: bits per element.
- `N`, default 9: elements per frame. `IDX_W = $clog2(N)`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `load`  in  1  request to capture `ordenado` and start a frame; sampled only in IDLE.
- `ordenado`  in  WIDTH x [N-1:0]  parallel sorted array.
- `out_ready`  in  1  downstream accepts the current element.
- `out_valid`  out  1  `out_data` holds a valid element.
- `out_data`  out  WIDTH  current element; 0 whenever `out_valid`=0.
- `out_last`  out  1  current element is the last of the frame; only asserted together with `out_valid`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the last transfer.

## Operation
- **FSM states:** IDLE, SEND, DONE. Registered state; next-state and output logic are combinational.
- **IDLE**
  - `load`=1 at posedge: `buf[i] <= ordenado[i]` for all i, `idx <= start index`, next state SEND.
  - `load`=0: stay in IDLE.
- **SEND**
  - `out_valid`=1, `out_data`=`buf[idx]`.
  - `out_last`=1 when `idx` equals the end index.
  - On `out_valid && out_ready` at posedge: if last, go to DONE; otherwise step `idx`.
  - Without `out_ready`: hold `idx`. `out_data` and `out_last` stay stable.
- **DONE:** `done`=1 and `out_valid`=0 for exactly one cycle, then IDLE.
- **Ignored inputs:** `load` in SEND or DONE is ignored (not queued). Changes to `ordenado` after capture do not affect the frame in flight.
- **Index rules:** `idx` is IDX_W bits; it never leaves [0, N-1] and never wraps.
- **Default order:** start index 0, end index N-1, step +1.
- **Reset (`rst`=1):** immediately, without waiting for a clock edge:
  - state = IDLE, `idx` = 0, all `buf` entries = 0;
  - `out_valid`, `out_data`, `out_last`, `busy`, `done` = 0.
- **Reset mid-frame:** aborts the frame with no `done` pulse. The next accepted `load` starts a fresh frame from the start index.

## Timing
- **Start latency:** `load` sampled at edge k gives `out_valid`=1 from cycle k+1.
- **Throughput:** one element per cycle while `out_ready`=1.
- **Frame length:** with `out_ready` held high, N transfers on edges k+1..k+N, `done` in cycle k+N+1, IDLE in cycle k+N+2.
- **Back-to-back frames:** minimum period N+2 cycles (11 for N=9), with `load` held high.
- **Handshake:** `out_valid` never deasserts before its transfer. `out_ready` may toggle freely and is not required before `out_valid`.
- **`done` timing:** never coincides with `out_valid`.
- **`busy` timing:** rises the cycle after the `load` is sampled. Falls on entering IDLE, i.e. the cycle after `done`.

## Configuration
- **`SERIALIZADOR_REVERSE_EN` defined:** start index N-1, end index 0, step -1; elements are emitted in descending order. `out_last` is asserted with `buf[0]`.
- **`SERIALIZADOR_REVERSE_EN` not defined:** ascending order as described under Operation.
- **Unchanged in both builds:** all other behaviour and all timing.

## Test plan
- **Ascending frame:** `ordenado`={1,2,3,4,5,6,7,8,9} (index 0..8), `out_ready`=1, one-cycle `load` -> `out_data` 1..9 on 9 consecutive cycles, `out_last` with 9 only, `done` one cycle later, `busy` low the cycle after.
- **Backpressure:** same frame, `out_ready` alternating 0,1 starting at 0 -> each value held stable while not ready, 9 transfers over 18 cycles, no element dropped or repeated.
- **Ignored inputs:** pulse `load` again during SEND and change `ordenado` to all 0xF after capture -> the original 1..9 sequence is unaffected and no second frame starts.
- **Reset mid-frame:** assert `rst` asynchronously after the 4th transfer -> all outputs 0 immediately with no `done`. Release `rst`, then load {9,8,...,1} -> stream starts at 9.
- **Back-to-back frames:** `load` held high and `out_ready`=1 -> frames start every 11 cycles, and `done` pulses every 11 cycles.
- **Reverse build:** with `SERIALIZADOR_REVERSE_EN` defined, load {1..9} -> stream 9,8,...,1 with `out_last` on 1.
